neighbor_fetch_sequencer: RTL

Memory-stage controller for the 3-lane, 18-bit vector pipeline of the filter GPU. Takes the 19-bit pixel base address formed by the execute-stage ALU and reads the pixels at base-1, base and base+1 from the single-port data memory, one read at a time. It assembles the three words into a lane vector and stalls the pipeline until the vector is complete.

---
 rtl/neighbor_fetch_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/neighbor_fetch_sequencer.sv
// Purpose : fetches mem[base-1], mem[base], mem[base+1] one read at a time and assembles a 3-lane vector.
// Latency : start at cycle 0 -> done at cycle 7 with mem_ready=1 and rvalid one cycle after accept.
// Backpr. : mem_req/mem_addr held stable until mem_ready; upstream frozen via stall until the vector is done.
//
// Ports:
//   clk, rst_n             pipeline clock, asynchronous active-low reset
//   start, base_addr       load request (sampled in IDLE only) and centre pixel address
//   flush                  abort the current fetch
//   stall                  freeze upstream pipeline registers
//   done, lane_data        one-cycle completion pulse; [0]=mem[base-1], [1]=mem[base], [2]=mem[base+1]
//   mem_req, mem_addr      read request / address to the single-port data memory
//   mem_ready              memory accepts the request this cycle
//   mem_rvalid, mem_rdata  read return (at most one read outstanding)
//
// Optional build macro: NEIGHBOR_CLAMP_EN clamps edge addresses to [0, MAX_ADDR]
// instead of wrapping modulo 2^ADDR_W.

module neighbor_fetch_sequencer #(
    parameter int                ADDR_W   = 19,
    parameter int                DATA_W   = 18,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 19'h7FFFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   flush,
    output logic                   stall,
    output logic                   done,
    output logic [2:0][DATA_W-1:0] lane_data,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ready,
    input  logic                   mem_rvalid,
    input  logic [DATA_W-1:0]      mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_in;
    logic [ADDR_W-1:0] addr_lo;
    logic [ADDR_W-1:0] addr_hi;
    logic              load_base;
    logic              capture;

    // Neighbour addresses are derived from the registered base so mem_addr
    // stays stable for the whole time a request waits for mem_ready.
`ifdef NEIGHBOR_CLAMP_EN
    assign base_in = (base_addr > MAX_ADDR) ? MAX_ADDR : base_addr;
    assign addr_lo = (base_q == '0) ? '0 : (base_q - ADDR_ONE);
    assign addr_hi = (base_q >= MAX_ADDR) ? MAX_ADDR : (base_q + ADDR_ONE);
`else
    logic unused_max_addr;
    assign unused_max_addr = ^MAX_ADDR;
    assign base_in = base_addr;
    assign addr_lo = base_q - ADDR_ONE;
    assign addr_hi = base_q + ADDR_ONE;
`endif

    always_comb begin
        case (lane_q)
            2'd0:    mem_addr = addr_lo;
            2'd1:    mem_addr = base_q;
            default: mem_addr = addr_hi;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        load_base = 1'b0;
        capture   = 1'b0;
        stall     = 1'b0;
        done      = 1'b0;
        mem_req   = 1'b0;

        case (state_q)
            IDLE: begin
                // flush wins over a simultaneous start: request is dropped
                if (start && !flush) begin
                    stall     = 1'b1;
                    load_base = 1'b1;
                    lane_d    = 2'd0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        capture = 1'b1;
                        if (lane_q == 2'd2) begin
                            state_d = DONE;
                        end else begin
                            lane_d  = lane_q + 2'd1;
                            state_d = ISSUE;
                        end
                    end
                end else if (flush) begin
                    // read still in flight: swallow its return before accepting new work
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                // stall low here lets the pipeline advance and take lane_data
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lane_q    <= 2'd0;
            base_q    <= '0;
            lane_data <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (load_base) begin
                base_q <= base_in;
            end
            if (capture) begin
                case (lane_q)
                    2'd0:    lane_data[0] <= mem_rdata;
                    2'd1:    lane_data[1] <= mem_rdata;
                    default: lane_data[2] <= mem_rdata;
                endcase
            end
        end
    end

endmodule
